// File: rtl/fetch_pkg.sv
// Shared widths, FSM states and the packet FIFO entry layout for the fetch controller.
package fetch_pkg;

    localparam int unsigned PKT_W = 128;
    localparam int unsigned VPC_W = 28;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [PKT_W-1:0] packet;
        logic [VPC_W-1:0] vpc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_pkt_fifo.sv
// Synchronous packet FIFO with a flush clear; head entry is read straight from storage.
module fetch_pkt_fifo #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, throttles fetch requests on FIFO occupancy,
// buffers completed packets and hands them to decode; pipe_flush redirects everything.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [VPC_W-1:0] RESET_PC = '0,
    parameter int unsigned      DEPTH    = 2
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst_n,
    input  logic             pipe_flush,
    input  logic [VPC_W-1:0] pipe_flush_pc,
    output logic             f_valid,
    output logic [VPC_W-1:0] fc2ft_virtpc,
    input  logic             f2d_done,
    input  logic [PKT_W-1:0] f2d_out_packet,
    input  logic [VPC_W-1:0] f2d_out_virtpc,
    output logic             fc2d_valid,
    output logic [PKT_W-1:0] fc2d_packet,
    output logic [VPC_W-1:0] fc2d_virtpc,
    input  logic             d2fc_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e           state_q;
    logic [VPC_W-1:0] pc_q;
    logic             f_valid_q;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // A flush discards both the packet completing and the packet being consumed this cycle.
    assign push = f2d_done & f_valid_q & ~pipe_flush;
    assign pop  = fc2d_valid & d2fc_ready & ~pipe_flush;

    assign wr_entry.packet = f2d_out_packet;
    assign wr_entry.vpc    = f2d_out_virtpc;

    fetch_pkt_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clkrst_core_clk),
        .rst_n_i (clkrst_core_rst_n),
        .clr_i   (pipe_flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (count)
    );

    // f_valid is registered alongside the state so it never depends on live inputs.
    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
        end else if (pipe_flush) begin
            state_q   <= S_FETCH;
            pc_q      <= pipe_flush_pc;
            f_valid_q <= 1'b1;
        end else begin
            if (push) begin
                pc_q <= pc_q + VPC_W'(1);
            end
            case (state_q)
                S_BOOT: begin
                    state_q   <= S_FETCH;
                    f_valid_q <= 1'b1;
                end
                S_FETCH: begin
                    if (push && !pop && (count == CNT_W'(DEPTH - 1))) begin
                        state_q   <= S_HOLD;
                        f_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (pop) begin
                        state_q   <= S_FETCH;
                        f_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_BOOT;
                    f_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign f_valid      = f_valid_q;
    assign fc2ft_virtpc = pc_q;
    assign fc2d_valid   = (count != '0);
    assign fc2d_packet  = head.packet;
    assign fc2d_virtpc  = head.vpc;

    f2d_done_needs_f_valid: assert property (
        @(posedge clkrst_core_clk) disable iff (!clkrst_core_rst_n) f2d_done |-> f_valid_q
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomised bench for fetch_ctrl against a queue-based model of fetch/decode traffic.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [27:0] RESET_PC = 28'h0000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pipe_flush = 1'b0;
    logic [27:0]  pipe_flush_pc = '0;
    logic         f_valid;
    logic [27:0]  fc2ft_virtpc;
    logic         f2d_done = 1'b0;
    logic [127:0] f2d_out_packet = '0;
    logic [27:0]  f2d_out_virtpc = '0;
    logic         fc2d_valid;
    logic [127:0] fc2d_packet;
    logic [27:0]  fc2d_virtpc;
    logic         d2fc_ready = 1'b0;

    fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .pipe_flush        (pipe_flush),
        .pipe_flush_pc     (pipe_flush_pc),
        .f_valid           (f_valid),
        .fc2ft_virtpc      (fc2ft_virtpc),
        .f2d_done          (f2d_done),
        .f2d_out_packet    (f2d_out_packet),
        .f2d_out_virtpc    (f2d_out_virtpc),
        .fc2d_valid        (fc2d_valid),
        .fc2d_packet       (fc2d_packet),
        .fc2d_virtpc       (fc2d_virtpc),
        .d2fc_ready        (d2fc_ready)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: packets waiting for decode, fetch PC, and the one boot cycle after reset.
    fetch_entry_t m_q[$];
    logic [27:0]  m_pc     = '0;
    logic         m_boot   = 1'b1;
    logic         m_fvalid = 1'b0;
    logic         m_init   = 1'b0;
    logic         m_rst    = 1'b0;
    logic [27:0]  seq_pc   = '0;

    task automatic pin(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_boot = 1'b1;
            m_init = 1'b1;
            m_rst  = 1'b1;
        end else if (pipe_flush) begin
            m_q.delete();
            m_pc   = pipe_flush_pc;
            m_boot = 1'b0;
            m_rst  = 1'b0;
        end else begin
            if (d2fc_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (f2d_done && m_fvalid) begin
                m_q.push_back('{packet: f2d_out_packet, vpc: f2d_out_virtpc});
                m_pc = m_pc + 28'd1;
            end
            m_boot = 1'b0;
            m_rst  = 1'b0;
        end
        m_fvalid = !m_boot && (m_q.size() < DEPTH);
    end

    // Every-cycle comparison plus an in-order PC sequence check on each decode acceptance.
    always @(negedge clk) begin
        if (m_init) begin
            pin("f_valid", 128'(f_valid), 128'(m_fvalid));
            pin("fc2ft_virtpc", 128'(fc2ft_virtpc), 128'(m_pc));
            pin("fc2d_valid", 128'(fc2d_valid), 128'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                pin("head_virtpc", 128'(fc2d_virtpc), 128'(m_q[0].vpc));
                pin("head_packet", fc2d_packet, m_q[0].packet);
            end
            if (m_rst) begin
                pin("rst_packet", fc2d_packet, 128'd0);
                pin("rst_virtpc", 128'(fc2d_virtpc), 128'd0);
            end
            if (!rst_n) seq_pc = RESET_PC;
            else if (pipe_flush) seq_pc = pipe_flush_pc;
            else if (fc2d_valid && d2fc_ready) begin
                pin("pop_sequence", 128'(fc2d_virtpc), 128'(seq_pc));
                seq_pc = seq_pc + 28'd1;
            end
        end
    end

    task automatic drive(input logic rst, input logic fl, input logic [27:0] fpc,
                         input logic want, input logic rdy);
        @(posedge clk);
        #1;
        rst_n          = rst;
        pipe_flush     = fl;
        pipe_flush_pc  = fpc;
        d2fc_ready     = rdy;
        f2d_done       = want && m_fvalid && rst;
        f2d_out_virtpc = m_pc;
        f2d_out_packet = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [27:0] exp_pc [4];
        exp_pc = '{28'd0, 28'd1, 28'd2, 28'd3};

        // 1: boot bubble then zero-bubble streaming
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 1);
        @(negedge clk); pin("t1_boot_fvalid", 128'(f_valid), 128'd0);
        drive(1, 0, 0, 1, 1);
        @(negedge clk); pin("t1_fetch_fvalid", 128'(f_valid), 128'd1);
        pin("t1_empty", 128'(fc2d_valid), 128'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 1);
            @(negedge clk);
            pin("t1_stream_pc", 128'(fc2d_virtpc), 128'(exp_pc[k]));
            pin("t1_stream_valid", 128'(fc2d_valid), 128'd1);
        end

        // 2: backpressure fills FIFO, then release
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        @(negedge clk); pin("t2_hold_fvalid", 128'(f_valid), 128'd0);
        pin("t2_head0", 128'(fc2d_virtpc), 128'd0);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 0);
        @(negedge clk); pin("t2_resume_fvalid", 128'(f_valid), 128'd1);
        pin("t2_head1", 128'(fc2d_virtpc), 128'd1);
        drive(1, 0, 0, 1, 0);
        @(negedge clk); pin("t2_refill_fvalid", 128'(f_valid), 128'd0);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        @(negedge clk); pin("t2_head2", 128'(fc2d_virtpc), 128'd2);

        // 3: flush with a coincident completion and one buffered entry
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 28'h0001234, 1, 1);
        drive(1, 0, 0, 0, 1);
        @(negedge clk); pin("t3_valid", 128'(fc2d_valid), 128'd0);
        pin("t3_pc", 128'(fc2ft_virtpc), 128'h0001234);
        pin("t3_fvalid", 128'(f_valid), 128'd1);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        @(negedge clk); pin("t3_head", 128'(fc2d_virtpc), 128'h0001234);

        // 4: PC wrap
        drive(1, 1, 28'hFFFFFFF, 0, 1);
        drive(1, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        @(negedge clk); pin("t4_head_max", 128'(fc2d_virtpc), 128'hFFFFFFF);
        drive(1, 0, 0, 1, 1);
        @(negedge clk); pin("t4_head_wrap", 128'(fc2d_virtpc), 128'h0);

        // 5: reset while full and stalled
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        @(negedge clk); pin("t5_full_fvalid", 128'(f_valid), 128'd0);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        pin("t5_fvalid", 128'(f_valid), 128'd0);
        pin("t5_valid", 128'(fc2d_valid), 128'd0);
        pin("t5_packet", fc2d_packet, 128'd0);
        pin("t5_virtpc", 128'(fc2d_virtpc), 128'd0);
        pin("t5_pc", 128'(fc2ft_virtpc), 128'(RESET_PC));

        // 6: random traffic with flushes and occasional resets
        for (int n = 0; n < 10000; n++) begin
            int unsigned r;
            logic [27:0] fpc;
            r   = $urandom_range(0, 199);
            fpc = (r == 0) ? 28'hFFFFFFE : 28'($urandom);
            drive(r != 199, r < 4, fpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        drive(1, 0, 0, 0, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
